// File: rtl/mem_sweep_sequencer.sv
// mem_sweep_sequencer
// Request generator for memory_block. On start it optionally writes an
// address-derived pattern over [start_addr, end_addr), then reads the same
// range back one access per clock. It checks the returned data, measures
// misses from the block's cumulative miss counter and produces a Q0.16 miss
// rate with a 17-step serial restoring divider.
module mem_sweep_sequencer #(
   parameter int                  ADDRESS_LEN  = 15,
   parameter int                  WORD_LEN     = 32,
   parameter int                  READ_LATENCY = 1,   // legal range 1..4
   parameter logic [WORD_LEN-1:0] DATA_SEED    = 32'hA5A5_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDRESS_LEN-1:0] start_addr,
   input  logic [ADDRESS_LEN-1:0] end_addr,
   input  logic                   write_pass,
   output logic [ADDRESS_LEN-1:0] mem_address,
   output logic                   mem_write,
   output logic                   mem_read,
   output logic [WORD_LEN-1:0]    mem_data_in,
   input  logic [WORD_LEN-1:0]    mem_data_out,
   input  logic [ADDRESS_LEN-1:0] miss_counter,
   output logic                   busy,
   output logic                   done,
   output logic [ADDRESS_LEN-1:0] access_count,
   output logic [ADDRESS_LEN-1:0] miss_count,
   output logic [ADDRESS_LEN-1:0] hit_count,
   output logic [ADDRESS_LEN-1:0] mismatch_count,
   output logic [15:0]            miss_rate
);

   // Divider datapath is wide enough for (count << 16) plus one guard bit.
   localparam int                     DIV_W      = ADDRESS_LEN + 17;
   localparam logic [2:0]             DRAIN_LAST = 3'(READ_LATENCY);
   localparam logic [4:0]             DIV_LAST   = 5'd16;
   localparam logic [ADDRESS_LEN-1:0] A_ONE      = ADDRESS_LEN'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WSWEEP,
      S_RSWEEP,
      S_DRAIN,
      S_DIV,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   // Latched run parameters and sweep address.
   logic [ADDRESS_LEN-1:0] start_q;
   logic [ADDRESS_LEN-1:0] end_q;
   logic                   wp_q;
   logic [ADDRESS_LEN-1:0] addr_q;

   // Expected-address pipeline: one stage per cycle of read latency.
   logic                   pipe_vld  [READ_LATENCY];
   logic [ADDRESS_LEN-1:0] pipe_addr [READ_LATENCY];

   // Result registers.
   logic [ADDRESS_LEN-1:0] base_q;
   logic [ADDRESS_LEN-1:0] access_q;
   logic [ADDRESS_LEN-1:0] miss_q;
   logic [ADDRESS_LEN-1:0] hit_q;
   logic [ADDRESS_LEN-1:0] mismatch_q;
   logic [15:0]            rate_q;

   // Drain and divider control.
   logic [2:0]             drain_cnt_q;
   logic [4:0]             div_cnt_q;
   logic [DIV_W-1:0]       div_rem_q;
   logic [DIV_W-1:0]       div_dsr_q;
   logic [15:0]            div_quo_q;
   logic                   div_sat_q;

   // Combinational helpers.
   logic                   at_last;
   logic                   range_ok;
   logic [ADDRESS_LEN-1:0] miss_now;
   logic                   div_bit;
   logic [15:0]            div_quo_nxt;
   logic                   rd_bad;

   // Write data and expected read data for address a.
   function automatic logic [WORD_LEN-1:0] pattern(input logic [ADDRESS_LEN-1:0] a);
      return WORD_LEN'(a) ^ DATA_SEED;
   endfunction

   assign at_last     = (addr_q == end_q - A_ONE);
   assign range_ok    = (end_addr > start_addr);
   // Modular subtraction absorbs a wrap of the block's miss counter.
   assign miss_now    = miss_counter - base_q;
   assign div_bit     = (div_rem_q >= div_dsr_q);
   assign div_quo_nxt = {div_quo_q[14:0], div_bit};
   assign rd_bad      = pipe_vld[READ_LATENCY-1] &&
                        (mem_data_out != pattern(pipe_addr[READ_LATENCY-1]));

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: flops are written with <= so every register samples the
      // pre-edge value of the others, independent of block ordering.
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode and the memory-side/status outputs.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no branch
      // can leave one unassigned and infer a latch.
      state_d     = state_q;
      mem_write   = 1'b0;
      mem_read    = 1'b0;
      mem_address = addr_q;
      mem_data_in = '0;
      busy        = 1'b1;
      done        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (!range_ok)       state_d = S_DONE;
               else if (write_pass) state_d = S_WSWEEP;
               else                 state_d = S_RSWEEP;
            end
         end
         S_WSWEEP: begin
            mem_write   = 1'b1;
            mem_data_in = pattern(addr_q);
            if (at_last) state_d = S_RSWEEP;
         end
         S_RSWEEP: begin
            mem_read = 1'b1;
            if (at_last) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) state_d = S_DIV;
         end
         S_DIV: begin
            if (div_cnt_q == DIV_LAST) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sweep addressing, read checking, result counters and the divider.
   always_ff @(posedge clk) begin
      if (rst) begin
         start_q     <= '0;
         end_q       <= '0;
         wp_q        <= 1'b0;
         addr_q      <= '0;
         base_q      <= '0;
         access_q    <= '0;
         miss_q      <= '0;
         hit_q       <= '0;
         mismatch_q  <= '0;
         rate_q      <= '0;
         drain_cnt_q <= '0;
         div_cnt_q   <= '0;
         div_rem_q   <= '0;
         div_dsr_q   <= '0;
         div_quo_q   <= '0;
         div_sat_q   <= 1'b0;
         // NOTE: the expected-address pipeline is a handful of flops rather
         // than a RAM, so it is reset too; reads in flight at an abort must
         // never be compared against the next run.
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_vld[i]  <= 1'b0;
            pipe_addr[i] <= '0;
         end
      end else begin
         pipe_vld[0]  <= (state_q == S_RSWEEP);
         pipe_addr[0] <= addr_q;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
         end

         // Data checking only means something after a write sweep.
         if (wp_q && rd_bad) mismatch_q <= mismatch_q + A_ONE;

         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  start_q    <= start_addr;
                  end_q      <= end_addr;
                  wp_q       <= write_pass;
                  access_q   <= '0;
                  miss_q     <= '0;
                  hit_q      <= '0;
                  mismatch_q <= '0;
                  rate_q     <= '0;
                  if (range_ok) begin
                     addr_q <= start_addr;
                     if (!write_pass) base_q <= miss_counter;
                  end
               end
            end
            S_WSWEEP: begin
               if (at_last) begin
                  addr_q <= start_q;
                  base_q <= miss_counter;
               end else begin
                  addr_q <= addr_q + A_ONE;
               end
            end
            S_RSWEEP: begin
               access_q    <= access_q + A_ONE;
               drain_cnt_q <= '0;
               if (!at_last) addr_q <= addr_q + A_ONE;
            end
            S_DRAIN: begin
               drain_cnt_q <= drain_cnt_q + 3'd1;
               if (drain_cnt_q == DRAIN_LAST) begin
                  miss_q    <= miss_now;
                  hit_q     <= access_q - miss_now;
                  div_rem_q <= {1'b0, miss_now, 16'h0000};
                  div_dsr_q <= {1'b0, access_q, 16'h0000};
                  div_quo_q <= '0;
                  div_cnt_q <= '0;
                  // A quotient of 2^17 or more cannot be resolved by 17
                  // steps; flag it up front.
                  div_sat_q <= ({1'b0, miss_now} >= {access_q, 1'b0});
               end
            end
            S_DIV: begin
               if (div_bit) div_rem_q <= div_rem_q - div_dsr_q;
               div_dsr_q <= div_dsr_q >> 1;
               div_quo_q <= div_quo_nxt;
               div_cnt_q <= div_cnt_q + 5'd1;
               // On the last step div_quo_q[15] holds quotient bit 16.
               if (div_cnt_q == DIV_LAST)
                  rate_q <= (div_sat_q || div_quo_q[15]) ? 16'hFFFF : div_quo_nxt;
            end
            default: ;
         endcase
      end
   end

   assign access_count   = access_q;
   assign miss_count     = miss_q;
   assign hit_count      = hit_q;
   assign mismatch_count = mismatch_q;
   assign miss_rate      = rate_q;

endmodule

// File: tb/tb_mem_sweep_sequencer.sv
// Bench for mem_sweep_sequencer: a behavioural memory_block model, a driver
// that predicts each run's access stream and results, and a monitor that
// pops predictions whenever the DUT accesses memory or pulses done.
module tb_mem_sweep_sequencer;

   localparam int          AW   = 15;
   localparam int          WL   = 32;
   localparam int          RL   = 2;
   localparam logic [31:0] SEED = 32'hA5A5_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW-1:0] end_addr = '0;
   logic          write_pass = 1'b0;
   logic [AW-1:0] mem_address;
   logic          mem_write, mem_read;
   logic [WL-1:0] mem_data_in;
   logic [WL-1:0] mem_data_out = '0;
   logic [AW-1:0] miss_counter;
   logic          busy, done;
   logic [AW-1:0] access_count, miss_count, hit_count, mismatch_count;
   logic [15:0]   miss_rate;

   mem_sweep_sequencer #(
      .ADDRESS_LEN(AW), .WORD_LEN(WL), .READ_LATENCY(RL), .DATA_SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
      .end_addr(end_addr), .write_pass(write_pass), .mem_address(mem_address),
      .mem_write(mem_write), .mem_read(mem_read), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out), .miss_counter(miss_counter), .busy(busy),
      .done(done), .access_count(access_count), .miss_count(miss_count),
      .hit_count(hit_count), .mismatch_count(mismatch_count),
      .miss_rate(miss_rate)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_evt(input string name);
      n_checks++;
      $display("FAIL %s: event occurred, expected none (cycle %0d)", name, cyc);
   endtask

   // ---------------- memory_block model ----------------
   logic [WL-1:0] mem [0:(1<<AW)-1];
   bit            miss_map [0:(1<<AW)-1];
   bit            bad_map  [0:(1<<AW)-1];
   logic [AW-1:0] mc_cnt  = '0;
   logic [AW-1:0] mc_base = '0;
   assign miss_counter = mc_base + mc_cnt;

   logic          mp_v [RL];
   logic [AW-1:0] mp_a [RL];
   initial for (int i = 0; i < RL; i++) begin mp_v[i] = 1'b0; mp_a[i] = '0; end

   // A read presented in cycle t returns data and its miss update in t+RL.
   always @(negedge clk) begin : mem_model
      logic          ov;
      logic [AW-1:0] oa;
      ov = mp_v[RL-1];
      oa = mp_a[RL-1];
      for (int i = RL - 1; i > 0; i--) begin mp_v[i] = mp_v[i-1]; mp_a[i] = mp_a[i-1]; end
      mp_v[0] = mem_read;
      mp_a[0] = mem_address;
      if (mem_write) mem[mem_address] = mem_data_in;
      if (ov) begin
         mem_data_out = mem[oa] ^ (bad_map[oa] ? 32'h1 : 32'h0);
         if (miss_map[oa]) mc_cnt = mc_cnt + 1'b1;
      end else begin
         mem_data_out = $urandom;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [WL-1:0] data;
   } acc_t;

   typedef struct {
      logic [AW-1:0] acc, miss, hit, mm;
      logic [15:0]   rate;
      int            lat;
      int            t0;
   } res_t;

   acc_t acc_q[$];
   res_t res_q[$];
   bit   track_acc = 1'b0;
   int   done_seen = 0;
   bit   prev_done = 1'b0;

   always @(negedge clk) begin : monitor
      acc_t ea;
      res_t er;
      if (!rst) begin
         if (prev_done) begin
            check("done_one_cycle", done, 0);
            check("busy_after_done", busy, 0);
         end
         prev_done = done;
         if (track_acc && (mem_write || mem_read)) begin
            if (acc_q.size() == 0) fail_evt("unexpected_access");
            else begin
               ea = acc_q.pop_front();
               check("acc_kind", {mem_write, mem_read}, {ea.wr, !ea.wr});
               check("acc_addr", mem_address, ea.addr);
               if (ea.wr) check("acc_wdata", mem_data_in, ea.data);
            end
         end
         if (done) begin
            done_seen++;
            if (res_q.size() == 0) fail_evt("unexpected_done");
            else begin
               er = res_q.pop_front();
               check("access_count", access_count, er.acc);
               check("miss_count", miss_count, er.miss);
               check("hit_count", hit_count, er.hit);
               check("mismatch_count", mismatch_count, er.mm);
               check("miss_rate", miss_rate, er.rate);
               check("done_latency", cyc - er.t0, er.lat);
               check("busy_at_done", busy, 1);
               check("accesses_left", acc_q.size(), 0);
            end
         end
      end else begin
         prev_done = 1'b0;
      end
   end

   // ---------------- driver ----------------
   task automatic reset_checks(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_mem_read"}, mem_read, 0);
      check({tag, "_mem_write"}, mem_write, 0);
      check({tag, "_mem_address"}, mem_address, 0);
      check({tag, "_mem_data_in"}, mem_data_in, 0);
      check({tag, "_results"},
            {access_count, miss_count, hit_count, mismatch_count, miss_rate}, 0);
   endtask

   // Predict a run from the range rules, launch it and wait for done.
   task automatic run_case(input int sa, input int ea, input bit wp, input bit poke);
      logic [AW-1:0] s, e, a;
      int   n, misses, mm, seen0;
      bit   got;
      acc_t x;
      res_t r;
      s = AW'(sa);
      e = AW'(ea);
      n = (e > s) ? int'(e) - int'(s) : 0;
      misses = 0;
      mm = 0;
      if (n > 0 && wp)
         for (int i = 0; i < n; i++) begin
            a = s + AW'(i);
            x.wr = 1'b1; x.addr = a; x.data = {17'b0, a} ^ SEED;
            acc_q.push_back(x);
         end
      for (int i = 0; i < n; i++) begin
         a = s + AW'(i);
         x.wr = 1'b0; x.addr = a; x.data = '0;
         acc_q.push_back(x);
         if (miss_map[a]) misses++;
         if (wp && bad_map[a]) mm++;
      end
      r.acc  = AW'(n);
      r.miss = AW'(misses);
      r.hit  = AW'(n - misses);
      r.mm   = AW'(mm);
      if (n == 0)           r.rate = 16'h0000;
      else if (misses >= n) r.rate = 16'hFFFF;
      else                  r.rate = 16'((longint'(misses) * 65536) / n);
      r.lat = (n == 0) ? 1 : (wp ? 2 * n : n) + (RL + 1) + 17 + 1;
      track_acc = 1'b1;
      @(negedge clk);
      start = 1'b1; start_addr = s; end_addr = e; write_pass = wp;
      r.t0 = cyc;
      res_q.push_back(r);
      seen0 = done_seen;
      @(negedge clk);
      start = 1'b0;
      start_addr = AW'($urandom_range(0, 32767));
      end_addr   = AW'($urandom_range(0, 32767));
      write_pass = ~wp;
      got = 1'b0;
      for (int i = 0; i < r.lat + 20; i++) begin
         if (poke && i == 2) begin
            start = 1'b1; start_addr = AW'(0); end_addr = AW'(5); write_pass = 1'b1;
         end
         if (poke && i == 4) start = 1'b0;
         @(negedge clk);
         if (done_seen != seen0) begin got = 1'b1; break; end
      end
      if (!got) fail_evt("done_timeout");
      repeat (3) @(negedge clk);
   endtask

   task automatic set_range_maps(input int sa, input int ea, input int miss_mode);
      for (int a = sa; a < ea; a++) begin
         case (miss_mode)
            0:       miss_map[a] = 1'b0;
            1:       miss_map[a] = 1'b1;
            default: miss_map[a] = ($urandom_range(0, 2) == 0);
         endcase
         bad_map[a] = 1'b0;
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      int sa, ea, len;
      repeat (3) @(negedge clk);
      reset_checks("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Cold read: every access misses.
      set_range_maps(1024, 1032, 1);
      run_case(1024, 1032, 1'b0, 1'b0);

      // Write then read back, clean and with one corrupted word.
      set_range_maps(1024, 1040, 0);
      run_case(1024, 1040, 1'b1, 1'b0);
      bad_map[1030] = 1'b1;
      run_case(1024, 1040, 1'b1, 1'b0);
      bad_map[1030] = 1'b0;

      // Partial hits: every fourth read misses.
      set_range_maps(2048, 2064, 0);
      for (int a = 2048; a < 2064; a += 4) miss_map[a] = 1'b1;
      run_case(2048, 2064, 1'b1, 1'b0);

      // Miss counter wraps during the run.
      set_range_maps(3000, 3010, 0);
      for (int a = 3000; a < 3005; a++) miss_map[a] = 1'b1;
      mc_base = AW'(32766) - mc_cnt;
      repeat (2) @(negedge clk);
      run_case(3000, 3010, 1'b0, 1'b0);

      // Empty ranges.
      run_case(500, 500, 1'b1, 1'b0);
      run_case(10, 0, 1'b0, 1'b0);
      run_case(600, 599, 1'b1, 1'b0);

      // Start asserted while busy must not disturb the run.
      set_range_maps(4000, 4030, 2);
      run_case(4000, 4030, 1'b1, 1'b1);

      // Randomized runs.
      for (int k = 0; k < 12; k++) begin
         sa  = $urandom_range(0, 32000);
         len = $urandom_range(0, 40);
         if (len == 0) ea = ($urandom_range(0, 1) == 1 || sa < 5) ? sa : sa - $urandom_range(1, 5);
         else          ea = sa + len;
         set_range_maps(sa, ea, 2);
         for (int a = sa; a < ea; a++) bad_map[a] = ($urandom_range(0, 15) == 0);
         run_case(sa, ea, 1'($urandom_range(0, 1)), 1'b0);
      end

      // Reset in the middle of a long read sweep.
      track_acc = 1'b0;
      @(negedge clk);
      start = 1'b1; start_addr = AW'(1024); end_addr = AW'(2048); write_pass = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("midrun_busy", busy, 1);
      check("midrun_read", mem_read, 1);
      rst = 1'b1;
      @(negedge clk);
      reset_checks("abort");
      rst = 1'b0;
      track_acc = 1'b1;
      repeat (40) @(negedge clk);
      check("abort_no_pending", res_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_sweep_sequencer.md
Name: mem_sweep_sequencer

Overview:
- Upstream request generator for memory_block: drives address/write/read/data_in and consumes data_out and miss_counter.
- On a start command it issues an optional write sweep over an address range, then a read sweep, one access per clock.
- It checks read data against the written pattern and reports access, miss and hit counts, mismatches, and a Q0.16 miss rate computed by a serial divider.

Parameters:
- ADDRESS_LEN, 15, address width; matches memory_block.
- WORD_LEN, 32, data word width; matches memory_block.
- READ_LATENCY, 1, cycles from a read address being presented to valid mem_data_out and to the corresponding miss_counter update; legal range 1..4.
- DATA_SEED, 32'hA5A5_0000, XOR seed for the write/check pattern.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a run; sampled only in IDLE
- start_addr  in  ADDRESS_LEN  first address of the range (inclusive)
- end_addr  in  ADDRESS_LEN  end of the range (exclusive)
- write_pass  in  1  1 = write sweep before the read sweep
- mem_address  out  ADDRESS_LEN  to memory_block.address
- mem_write  out  1  to memory_block.write
- mem_read  out  1  to memory_block.read
- mem_data_in  out  WORD_LEN  to memory_block.data_in
- mem_data_out  in  WORD_LEN  from memory_block.data_out
- miss_counter  in  ADDRESS_LEN  cumulative miss count from memory_block
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when results are valid
- access_count  out  ADDRESS_LEN  reads issued in the last run
- miss_count  out  ADDRESS_LEN  misses during the read sweep
- hit_count  out  ADDRESS_LEN  access_count - miss_count
- mismatch_count  out  ADDRESS_LEN  read-data mismatches (write_pass runs only)
- miss_rate  out  16  miss_count/access_count in Q0.16, saturated

Behaviour:
- Reset: state IDLE. All outputs are 0, including mem_read, mem_write, mem_address, busy, done and every result register. Reset mid-run aborts immediately and clears everything.
- Pattern(a) = zero-extend(a) XOR DATA_SEED.
- States: IDLE, WSWEEP, RSWEEP, DRAIN, DIV, DONE.
- IDLE:
  - start=1 with end_addr > start_addr: latch the range and write_pass, clear the result registers, set busy=1, go to WSWEEP if write_pass else RSWEEP.
  - start=1 with end_addr <= start_addr: go to DONE with all results 0.
  - start while busy is ignored.
- WSWEEP:
  - Each cycle: mem_write=1, mem_read=0, mem_address=a, mem_data_in=Pattern(a).
  - a runs from start_addr to end_addr-1.
  - The cycle after the last write enters RSWEEP; there is no idle gap.
- RSWEEP:
  - Each cycle: mem_read=1, mem_write=0, mem_address=a, a from start_addr to end_addr-1.
  - On entry, snapshot miss_counter as the base.
  - access_count increments per issued read.
  - Each issued address enters a READ_LATENCY-deep expected-address pipeline.
  - When an entry emerges, mem_data_out is compared with Pattern(addr); on inequality mismatch_count increments (write_pass runs only).
- DRAIN:
  - mem_read=0, mem_write=0, mem_address holds its last value.
  - Lasts READ_LATENCY+1 cycles, letting the last compare and miss update land.
  - On exit: miss_count = miss_counter - base, modulo 2^ADDRESS_LEN so counter wrap is handled; hit_count = access_count - miss_count.
- DIV:
  - 17-cycle restoring division of (miss_count << 16) by access_count.
  - A quotient of 65536 or more saturates miss_rate to 16'hFFFF.
- DONE:
  - done=1 for exactly one cycle, busy drops, then IDLE.
  - Results hold until the next accepted start.
- busy is 1 from the cycle after start is accepted through the DONE cycle.
- Address arithmetic is ADDRESS_LEN wide. end_addr = 0 is treated as "less than or equal", so that run is empty.

Test Plan:
- Reset check: assert rst mid-RSWEEP with start_addr=1024, end_addr=2048 -> the next cycle shows all outputs 0, state IDLE, and no done pulse.
- Cold read run: write_pass=0, start_addr=1024, end_addr=1032, memory model missing every access -> exactly 8 mem_read cycles on addresses 1024..1031, access_count=8, miss_count=8, hit_count=0, miss_rate=16'hFFFF. done arrives 8+(READ_LATENCY+1)+17+1 cycles after start.
- Write/read check: write_pass=1, range 1024..1039 -> 16 writes of Pattern(a), then 16 reads, mismatch_count=0. Corrupting data_out at address 1030 gives mismatch_count=1.
- Partial hits: misses on 4 of 16 reads -> miss_count=4, hit_count=12, miss_rate=16'h4000.
- Counter wrap: miss_counter base = 2^ADDRESS_LEN - 2 with 5 misses during the run -> miss_count=5.
- Empty range plus ignored start: end_addr=start_addr=500 -> done pulses with all results 0 and no mem_read/mem_write activity. A start asserted during a busy run has no effect on that run.
